// File: rtl/sound_sequencer.sv
// Plays fixed square-wave note sequences requested by the game-state FSM.
// Optional SOUND_MUTE_EN adds a mute input that silences the speaker pin only.
module sound_sequencer #(
  parameter int HP_UNIT  = 3000,
  parameter int NOTE_LEN = 1200000,
  parameter int GAP_LEN  = 240000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [1:0] soundselector,
  input  logic       playsound,
`ifdef SOUND_MUTE_EN
  input  logic       mute,
`endif
  output logic       speaker,
  output logic       busy,
  output logic [1:0] cur_sound,
  output logic       done
);

  localparam int HP_W   = $clog2(HP_UNIT * 16);
  localparam int NOTE_W = (NOTE_LEN > 1) ? $clog2(NOTE_LEN) : 1;
  localparam int GAP_W  = (GAP_LEN > 1) ? $clog2(GAP_LEN) : 1;

  localparam logic [NOTE_W-1:0] NOTE_LAST = NOTE_W'(NOTE_LEN - 1);
  localparam logic [GAP_W-1:0]  GAP_LAST  = GAP_W'(GAP_LEN - 1);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_TONE = 2'd1;
  localparam logic [1:0] ST_GAP  = 2'd2;

  // Half-period multiplier k for a given sound and note index.
  function automatic logic [4:0] note_k(input logic [1:0] snd, input logic [1:0] idx);
    logic [4:0] k;
    case (snd)
      2'd0: k = 5'd4;
      2'd1: begin
        case (idx)
          2'd0:    k = 5'd8;
          2'd1:    k = 5'd6;
          default: k = 5'd4;
        endcase
      end
      2'd2: k = (idx == 2'd0) ? 5'd12 : 5'd16;
      default: begin
        case (idx)
          2'd0:    k = 5'd8;
          2'd1:    k = 5'd6;
          2'd2:    k = 5'd4;
          default: k = 5'd2;
        endcase
      end
    endcase
    return k;
  endfunction

  function automatic logic [1:0] last_idx(input logic [1:0] snd);
    logic [1:0] li;
    case (snd)
      2'd0:    li = 2'd0;
      2'd1:    li = 2'd2;
      2'd2:    li = 2'd1;
      default: li = 2'd3;
    endcase
    return li;
  endfunction

  // CRASH and CELEBRATION share the top priority level.
  function automatic logic [1:0] prio(input logic [1:0] snd);
    logic [1:0] p;
    case (snd)
      2'd0:    p = 2'd0;
      2'd1:    p = 2'd1;
      default: p = 2'd2;
    endcase
    return p;
  endfunction

  function automatic logic [HP_W-1:0] hp_term(input logic [4:0] k);
    return HP_W'(HP_UNIT * int'(k) - 1);
  endfunction

  logic [1:0]        state_r, state_nxt_s;
  logic [1:0]        note_idx_r, note_idx_nxt_s;
  logic [HP_W-1:0]   hp_cnt_r, hp_cnt_nxt_s;
  logic [NOTE_W-1:0] note_cnt_r, note_cnt_nxt_s;
  logic [GAP_W-1:0]  gap_cnt_r, gap_cnt_nxt_s;
  logic              tone_r, tone_nxt_s;
  logic              busy_nxt_s, done_nxt_s;
  logic [1:0]        cur_sound_nxt_s;
  logic              playsound_q_r;
  logic [1:0]        sel_q_r;
  logic              req_s, accept_s;
  logic [HP_W-1:0]   hp_last_s;

  assign req_s     = playsound & (~playsound_q_r | (soundselector != sel_q_r));
  assign accept_s  = req_s & ((state_r == ST_IDLE) | (prio(soundselector) >= prio(cur_sound)));
  assign hp_last_s = hp_term(note_k(cur_sound, note_idx_r));

  // Next-state logic; an accepted request overrides every other transition.
  always_comb begin
    state_nxt_s     = state_r;
    note_idx_nxt_s  = note_idx_r;
    hp_cnt_nxt_s    = hp_cnt_r;
    note_cnt_nxt_s  = note_cnt_r;
    gap_cnt_nxt_s   = gap_cnt_r;
    tone_nxt_s      = tone_r;
    busy_nxt_s      = busy;
    cur_sound_nxt_s = cur_sound;
    done_nxt_s      = 1'b0;
    if (accept_s) begin
      state_nxt_s     = ST_TONE;
      cur_sound_nxt_s = soundselector;
      note_idx_nxt_s  = 2'd0;
      hp_cnt_nxt_s    = {HP_W{1'b0}};
      note_cnt_nxt_s  = {NOTE_W{1'b0}};
      gap_cnt_nxt_s   = {GAP_W{1'b0}};
      tone_nxt_s      = 1'b0;
      busy_nxt_s      = 1'b1;
    end else begin
      case (state_r)
        ST_IDLE: begin
          tone_nxt_s = 1'b0;
        end
        ST_TONE: begin
          if (hp_cnt_r == hp_last_s) begin
            hp_cnt_nxt_s = {HP_W{1'b0}};
            tone_nxt_s   = ~tone_r;
          end else begin
            hp_cnt_nxt_s = hp_cnt_r + HP_W'(1);
          end
          if (note_cnt_r == NOTE_LAST) begin
            note_cnt_nxt_s = {NOTE_W{1'b0}};
            hp_cnt_nxt_s   = {HP_W{1'b0}};
            tone_nxt_s     = 1'b0;
            if (note_idx_r == last_idx(cur_sound)) begin
              state_nxt_s = ST_IDLE;
              busy_nxt_s  = 1'b0;
              done_nxt_s  = 1'b1;
            end else begin
              state_nxt_s   = ST_GAP;
              gap_cnt_nxt_s = {GAP_W{1'b0}};
            end
          end else begin
            note_cnt_nxt_s = note_cnt_r + NOTE_W'(1);
          end
        end
        ST_GAP: begin
          tone_nxt_s = 1'b0;
          if (gap_cnt_r == GAP_LAST) begin
            state_nxt_s    = ST_TONE;
            note_idx_nxt_s = note_idx_r + 2'd1;
            gap_cnt_nxt_s  = {GAP_W{1'b0}};
            hp_cnt_nxt_s   = {HP_W{1'b0}};
            note_cnt_nxt_s = {NOTE_W{1'b0}};
          end else begin
            gap_cnt_nxt_s = gap_cnt_r + GAP_W'(1);
          end
        end
        default: begin
          state_nxt_s = ST_IDLE;
          busy_nxt_s  = 1'b0;
          tone_nxt_s  = 1'b0;
        end
      endcase
    end
  end

  // State, counters, request-edge history and registered status outputs.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r       <= ST_IDLE;
      note_idx_r    <= 2'd0;
      hp_cnt_r      <= {HP_W{1'b0}};
      note_cnt_r    <= {NOTE_W{1'b0}};
      gap_cnt_r     <= {GAP_W{1'b0}};
      tone_r        <= 1'b0;
      busy          <= 1'b0;
      cur_sound     <= 2'd0;
      done          <= 1'b0;
      playsound_q_r <= 1'b0;
      sel_q_r       <= 2'd0;
    end else begin
      state_r       <= state_nxt_s;
      note_idx_r    <= note_idx_nxt_s;
      hp_cnt_r      <= hp_cnt_nxt_s;
      note_cnt_r    <= note_cnt_nxt_s;
      gap_cnt_r     <= gap_cnt_nxt_s;
      tone_r        <= tone_nxt_s;
      busy          <= busy_nxt_s;
      cur_sound     <= cur_sound_nxt_s;
      done          <= done_nxt_s;
      playsound_q_r <= playsound;
      sel_q_r       <= soundselector;
    end
  end

`ifdef SOUND_MUTE_EN
  // Gated copy of the toggle flop; the toggle itself keeps its phase while muted.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      speaker <= 1'b0;
    end else begin
      speaker <= tone_nxt_s & ~mute;
    end
  end
`else
  assign speaker = tone_r;
`endif

endmodule
